exe_muldiv_seq: RTL and testbench

EXE_MULDIV_SEQ -- requirements
Module: exe_muldiv_seq

---
 rtl/exe_muldiv_seq.sv | 218 +++++++++++++++++++++
 tb/tb_exe_muldiv_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_seq.sv
// Sequential RV64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle special cases and pipeline stall control.
module exe_muldiv_seq (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        MD_START,
    input  logic [2:0]  MD_FUNC3,
    input  logic        MD_WORD,
    input  logic [63:0] MD_A,
    input  logic [63:0] MD_B,
    input  logic        MD_FLUSH,
    output logic        V_MD_STALL,
    output logic        MD_DONE,
    output logic [63:0] MD_RESULT,
    output logic        MD_BUSY
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned CW   = 7;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_p;
    logic [PW-1:0]     r_mc;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_func3;
    logic              r_word;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;
    logic              r_done;
    logic              r_busy;

    logic              w_go;
    logic              w_is_div;
    logic              w_sext_w;
    logic              w_a_signed;
    logic              w_b_signed;
    logic [XLEN-1:0]   w_a_ext;
    logic [XLEN-1:0]   w_b_ext;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_div_init;
    logic [XLEN-1:0]   w_most_neg;
    logic              w_illegal;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_sel;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_rsub;
    logic [PW-1:0]     w_div_next;
    logic [PW-1:0]     w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_sel;
    logic [XLEN-1:0]   w_fix_res;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Operand extension, signedness and magnitudes for the op presented in IDLE
    always_comb begin
        w_go       = MD_START && !MD_FLUSH;
        w_is_div   = MD_FUNC3[2];
        w_sext_w   = !(MD_FUNC3[2] && MD_FUNC3[0]);
        w_a_signed = !(MD_FUNC3 == 3'd3 || MD_FUNC3 == 3'd5 || MD_FUNC3 == 3'd7);
        w_b_signed = (MD_FUNC3 == 3'd0 || MD_FUNC3 == 3'd1 ||
                      MD_FUNC3 == 3'd4 || MD_FUNC3 == 3'd6);
        if (MD_WORD) begin
            w_a_ext = w_sext_w ? sext32(MD_A) : {32'b0, MD_A[31:0]};
            w_b_ext = w_sext_w ? sext32(MD_B) : {32'b0, MD_B[31:0]};
        end else begin
            w_a_ext = MD_A;
            w_b_ext = MD_B;
        end
        w_a_neg    = w_a_signed && w_a_ext[XLEN-1];
        w_b_neg    = w_b_signed && w_b_ext[XLEN-1];
        w_a_mag    = w_a_neg ? (XLEN'(0) - w_a_ext) : w_a_ext;
        w_b_mag    = w_b_neg ? (XLEN'(0) - w_b_ext) : w_b_ext;
        // W dividends start in the upper half so 32 steps consume all their bits
        w_div_init = MD_WORD ? {w_a_mag[31:0], 32'b0} : w_a_mag;
        w_most_neg = MD_WORD ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        w_illegal  = MD_WORD && !MD_FUNC3[2] && (MD_FUNC3 != 3'd0);
        w_div_zero = w_is_div && (w_b_ext == XLEN'(0));
        w_ovf      = w_is_div && !MD_FUNC3[0] && (w_a_ext == w_most_neg) &&
                     (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF);
        w_special  = w_illegal || w_div_zero || w_ovf;
        if (w_div_zero)
            w_special_sel = MD_FUNC3[1] ? w_a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            w_special_sel = MD_FUNC3[1] ? XLEN'(0) : w_a_ext;
        if (w_illegal)
            w_special_res = '0;
        else
            w_special_res = MD_WORD ? sext32(w_special_sel) : w_special_sel;
    end

    // One restoring-divide step on {remainder, quotient}
    always_comb begin
        w_rsh      = {r_p[PW-1:XLEN], r_p[XLEN-1]};
        w_rsub     = w_rsh - {1'b0, r_b};
        if (!w_rsub[XLEN])
            w_div_next = {w_rsub[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
        else
            w_div_next = {w_rsh[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
    end

    // Sign fix-up and result selection
    always_comb begin
        w_prod_fix = r_neg_res ? (PW'(0) - r_p) : r_p;
        w_quo_fix  = r_neg_res ? (XLEN'(0) - r_p[XLEN-1:0]) : r_p[XLEN-1:0];
        w_rem_fix  = r_neg_rem ? (XLEN'(0) - r_p[PW-1:XLEN]) : r_p[PW-1:XLEN];
        case (r_func3)
            3'd0:       w_fix_sel = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       w_fix_sel = w_prod_fix[PW-1:XLEN];
            3'd4, 3'd5: w_fix_sel = w_quo_fix;
            default:    w_fix_sel = w_rem_fix;
        endcase
        w_fix_res = r_word ? sext32(w_fix_sel) : w_fix_sel;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        V_MD_STALL = 1'b0;
        case (r_state)
            S_IDLE: begin
                V_MD_STALL = RESET_N && w_go;
                if (w_go) w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                V_MD_STALL = RESET_N;
                if (MD_FLUSH)                 w_next = S_IDLE;
                else if (r_cnt == CW'(1))     w_next = S_FIX;
            end
            S_FIX: begin
                V_MD_STALL = RESET_N;
                w_next     = MD_FLUSH ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status flags registered alongside the state
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= (w_next == S_DONE);
            r_busy <= (w_next != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_mc      <= '0;
            r_b       <= '0;
            r_func3   <= '0;
            r_word    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_func3   <= MD_FUNC3;
                    r_word    <= MD_WORD;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_cnt     <= MD_WORD ? CW'(32) : CW'(64);
                    r_b       <= w_b_mag;
                    if (w_is_div) begin
                        r_p  <= {XLEN'(0), w_div_init};
                        r_mc <= '0;
                    end else begin
                        r_p  <= '0;
                        r_mc <= {XLEN'(0), w_a_mag};
                    end
                    if (w_special) r_result <= w_special_res;
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_func3[2]) begin
                        r_p <= w_div_next;
                    end else begin
                        if (r_b[0]) r_p <= r_p + r_mc;
                        r_mc <= r_mc << 1;
                        r_b  <= r_b >> 1;
                    end
                end
                S_FIX: if (!MD_FLUSH) r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign MD_DONE   = r_done;
    assign MD_BUSY   = r_busy;
    assign MD_RESULT = r_result;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed self-checking bench for exe_muldiv_seq: latency, results, stall,
// special cases, flush and mid-op reset.
module tb_exe_muldiv_seq;

    logic        clk;
    logic        RESET_N;
    logic        MD_START;
    logic [2:0]  MD_FUNC3;
    logic        MD_WORD;
    logic [63:0] MD_A;
    logic [63:0] MD_B;
    logic        MD_FLUSH;
    logic        V_MD_STALL;
    logic        MD_DONE;
    logic [63:0] MD_RESULT;
    logic        MD_BUSY;

    int          n_pass;
    int          n_total;
    logic [63:0] last_res;

    exe_muldiv_seq dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .MD_START   (MD_START),
        .MD_FUNC3   (MD_FUNC3),
        .MD_WORD    (MD_WORD),
        .MD_A       (MD_A),
        .MD_B       (MD_B),
        .MD_FLUSH   (MD_FLUSH),
        .V_MD_STALL (V_MD_STALL),
        .MD_DONE    (MD_DONE),
        .MD_RESULT  (MD_RESULT),
        .MD_BUSY    (MD_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Present an op in IDLE, hold MD_START while stalled, and check the outcome
    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat);
        int lat;
        int stall_n;
        bit got_done;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(MD_BUSY), 64'd0);
        chk({tag, "_idle_done"}, 64'(MD_DONE), 64'd0);
        MD_FUNC3 = f3;
        MD_WORD  = w;
        MD_A     = a;
        MD_B     = b;
        MD_START = 1'b1;
        #1;
        chk({tag, "_start_stall"}, 64'(V_MD_STALL), 64'd1);
        lat      = 0;
        stall_n  = 0;
        got_done = 1'b0;
        while (!got_done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (MD_DONE) got_done = 1'b1;
            else if (V_MD_STALL) stall_n++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, MD_RESULT, exp_res);
        chk({tag, "_done_stall"}, 64'(V_MD_STALL), 64'd0);
        chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_lat - 1));
        MD_START = 1'b0;
        last_res = exp_res;
    endtask

    initial begin
        int dn;
        n_pass   = 0;
        n_total  = 0;
        last_res = '0;
        RESET_N  = 1'b0;
        MD_START = 1'b1;
        MD_FLUSH = 1'b0;
        MD_FUNC3 = 3'd0;
        MD_WORD  = 1'b0;
        MD_A     = 64'd3;
        MD_B     = 64'd4;

        #12;
        chk("rst_result", MD_RESULT, 64'd0);
        chk("rst_done",   64'(MD_DONE), 64'd0);
        chk("rst_busy",   64'(MD_BUSY), 64'd0);
        chk("rst_stall",  64'(V_MD_STALL), 64'd0);
        @(negedge clk);
        MD_START = 1'b0;
        RESET_N  = 1'b1;

        run_op("mul_7_m3",     3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu_max",    3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("div_by0",      3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem_by0",      3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        run_op("divw_ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("rem_m7_2",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divuw",        3'd5, 1'b1, 64'h0000_0001_0000_0010, 64'd4, 64'd4, 34);
        run_op("mulh_m2_3",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulhsu",       3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div_m20_6",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("divu_100_7",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
        run_op("remu_100_7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66);
        run_op("mulw",         3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("mulw_illegal", 3'd1, 1'b1, 64'd9, 64'd9, 64'd0, 1);
        run_op("remw_m7_2",    3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("div_ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divu_again",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);

        // Flush wins over a simultaneous start
        @(negedge clk);
        MD_FUNC3 = 3'd0;
        MD_WORD  = 1'b0;
        MD_A     = 64'd2;
        MD_B     = 64'd2;
        MD_START = 1'b1;
        MD_FLUSH = 1'b1;
        #1;
        chk("flush_start_stall", 64'(V_MD_STALL), 64'd0);
        @(negedge clk);
        MD_START = 1'b0;
        MD_FLUSH = 1'b0;
        chk("flush_start_busy", 64'(MD_BUSY), 64'd0);

        // Flush at the tenth CALC cycle
        MD_START = 1'b1;
        repeat (10) @(negedge clk);
        chk("flush_calc_busy", 64'(MD_BUSY), 64'd1);
        MD_FLUSH = 1'b1;
        @(negedge clk);
        MD_FLUSH = 1'b0;
        MD_START = 1'b0;
        chk("flush_idle_busy", 64'(MD_BUSY), 64'd0);
        chk("flush_no_done",   64'(MD_DONE), 64'd0);
        chk("flush_result",    MD_RESULT, last_res);
        run_op("mul_after_flush", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 66);

        // Reset in the middle of CALC
        @(negedge clk);
        MD_FUNC3 = 3'd0;
        MD_A     = 64'd11;
        MD_B     = 64'd13;
        MD_START = 1'b1;
        repeat (20) @(negedge clk);
        RESET_N = 1'b0;
        #1;
        chk("midrst_busy",   64'(MD_BUSY), 64'd0);
        chk("midrst_done",   64'(MD_DONE), 64'd0);
        chk("midrst_stall",  64'(V_MD_STALL), 64'd0);
        chk("midrst_result", MD_RESULT, 64'd0);
        @(negedge clk);
        MD_START = 1'b0;
        RESET_N  = 1'b1;
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            if (MD_DONE) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        run_op("mul_after_rst", 3'd0, 1'b0, 64'd11, 64'd13, 64'd143, 66);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
